// File: rtl/riscv_pkg.sv
// Shared RV32 constants: datapath width, writeback source select and load funct3 encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction, sign/zero extension and misalignment detection.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      ld_type_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o     = word_i;
    misalign_o = 1'b0;
    case (ld_type_i)
      LD_LB:  data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_lane};
      LD_LH: begin
        data_o     = {{(XLEN-16){half_lane[15]}}, half_lane};
        misalign_o = addr_lo_i[0];
      end
      LD_LHU: begin
        data_o     = {{(XLEN-16){1'b0}}, half_lane};
        misalign_o = addr_lo_i[0];
      end
      // LW and any undefined funct3 pass the full word through.
      default: misalign_o = (addr_lo_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: holds one retiring instruction, selects writeback data,
// drives the register file write port and counts retired instructions.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             wb_stall,
  input  logic             wb_flush,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_ld_type,
  input  logic [1:0]       mem_addr_lo,
  input  logic [XLEN-1:0]  mem_alu_res,
  input  logic [XLEN-1:0]  mem_pc_add4,
  input  logic [XLEN-1:0]  mem_dmem_rd,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd_valid,
  output logic             ld_misalign,
  output logic [CNT_W-1:0] instret
);

  logic             wb_valid_q;
  logic             wb_rf_we_q;
  logic [4:0]       wb_rd_q;
  logic [1:0]       wb_sel_q;
  logic [2:0]       wb_ld_type_q;
  logic [1:0]       wb_addr_lo_q;
  logic [XLEN-1:0]  wb_alu_q;
  logic [XLEN-1:0]  wb_pc4_q;
  logic [XLEN-1:0]  wb_dmem_q;
  logic [CNT_W-1:0] instret_q;

  logic            accept;
  logic            retire;
  logic [XLEN-1:0] ld_data;
  logic            ld_misalign_raw;
  logic            misalign_ret;

  assign mem_ready = ~wb_stall;
  assign accept    = mem_valid & mem_ready & ~wb_flush;
  assign retire    = wb_valid_q & ~wb_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_rf_we_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_sel_q     <= WB_SEL_ALU;
      wb_ld_type_q <= '0;
      wb_addr_lo_q <= '0;
      wb_alu_q     <= '0;
      wb_pc4_q     <= '0;
      wb_dmem_q    <= '0;
      instret_q    <= '0;
    end else begin
      if (accept) begin
        wb_valid_q   <= 1'b1;
        wb_rf_we_q   <= mem_rf_we;
        wb_rd_q      <= mem_rd;
        wb_sel_q     <= mem_wb_sel;
        wb_ld_type_q <= mem_ld_type;
        wb_addr_lo_q <= mem_addr_lo;
        wb_alu_q     <= mem_alu_res;
        wb_pc4_q     <= mem_pc_add4;
        wb_dmem_q    <= mem_dmem_rd;
      end else if (!wb_stall) begin
        wb_valid_q <= 1'b0;
      end
      // Free-running wrap; misaligned loads and x0 writes still retire.
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  load_extend u_load_extend (
    .word_i     (wb_dmem_q),
    .ld_type_i  (wb_ld_type_q),
    .addr_lo_i  (wb_addr_lo_q),
    .data_o     (ld_data),
    .misalign_o (ld_misalign_raw)
  );

  assign misalign_ret = (wb_sel_q == WB_SEL_LOAD) & ld_misalign_raw;

  always_comb begin
    rf_wd = wb_alu_q;
    case (wb_sel_q)
      WB_SEL_LOAD: rf_wd = ld_data;
      WB_SEL_PC4:  rf_wd = wb_pc4_q;
      default:     rf_wd = wb_alu_q;
    endcase
  end

  assign rf_wa       = wb_rd_q;
  assign rf_we       = retire & wb_rf_we_q & (wb_rd_q != 5'd0) & ~misalign_ret;
  assign fwd_valid   = rf_we;
  assign ld_misalign = retire & misalign_ret;
  assign instret     = instret_q;

endmodule
